// File: rtl/baud_gen_pkg.sv
// Shared constants and helpers for the UART baud tick generator.
// Latency: n/a (elaboration-time constants only). Backpressure: n/a.
// Provides clog2, rounded phase-increment calculation and a 50 MHz standard-rate table.
package baud_gen_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int ACC_W_DEF      = 16;
  localparam int FREQ_DEF       = 50_000_000;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // round(baud * os * 2^acc_w / freq), computed in 64 bits to avoid overflow
  function automatic int unsigned calc_inc(input int unsigned freq,
                                           input int unsigned baud,
                                           input int unsigned os,
                                           input int unsigned acc_w);
    longint unsigned num;
    num = 64'(baud) * 64'(os) * (64'd1 << acc_w) + 64'(freq / 2);
    return 32'(num / 64'(freq));
  endfunction

  typedef enum logic [1:0] {
    BAUD_9600   = 2'd0,
    BAUD_19200  = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baud_sel_e;

  localparam logic [ACC_W_DEF-1:0] STD_INC [4] = '{
    ACC_W_DEF'(calc_inc(FREQ_DEF, 9600,   OVERSAMPLE_DEF, ACC_W_DEF)),
    ACC_W_DEF'(calc_inc(FREQ_DEF, 19200,  OVERSAMPLE_DEF, ACC_W_DEF)),
    ACC_W_DEF'(calc_inc(FREQ_DEF, 57600,  OVERSAMPLE_DEF, ACC_W_DEF)),
    ACC_W_DEF'(calc_inc(FREQ_DEF, 115200, OVERSAMPLE_DEF, ACC_W_DEF))
  };

  function automatic logic [ACC_W_DEF-1:0] std_inc(input baud_sel_e sel);
    return STD_INC[sel];
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// Fractional phase accumulator; carry out of the low ACC_W bits is the oversample tick.
// Latency: carry registered, 1 cycle after the add. Backpressure: none, en gates the add.
// en=0 holds the low bits and clears the carry; sync (with en) zeroes the whole register.
module baud_phase_acc import baud_gen_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [ACC_W-1:0] inc,
  output logic             carry,
  output logic             carry_nxt
);

  logic [ACC_W:0] acc_q, acc_d;

  always_comb begin
    acc_d = {1'b0, acc_q[ACC_W-1:0]};
    if (en) begin
      if (sync) begin
        acc_d = '0;
      end else begin
        acc_d = {1'b0, acc_q[ACC_W-1:0]} + {1'b0, inc};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign carry     = acc_q[ACC_W];
  assign carry_nxt = acc_d[ACC_W];

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: oversample, 1x bit and (with BAUD_GEN_MID_TICK_EN) mid-bit ticks.
// Latency: all outputs registered; new increment takes effect the cycle after tick, en=0 or sync.
// Backpressure: cfg_ready stays low while an increment is pending, until a bit boundary applies it.
module baud_tick_gen import baud_gen_pkg::*; #(
  parameter int FREQ         = FREQ_DEF,
  parameter int DEFAULT_BAUD = 115200,
  parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
  parameter int ACC_W        = ACC_W_DEF
) (
  input  logic                          CLK50MHZ,
  input  logic                          RST_N,
  input  logic                          en,
  input  logic                          sync,
  input  logic                          cfg_valid,
  input  logic [ACC_W-1:0]              cfg_inc,
  output logic                          cfg_ready,
  output logic                          tick_os,
  output logic                          tick,
  output logic                          tick_mid,
  output logic [clog2(OVERSAMPLE)-1:0]  os_phase
);

  localparam int PW = clog2(OVERSAMPLE);
  localparam logic [ACC_W-1:0] INC_DEF = ACC_W'(calc_inc(FREQ, DEFAULT_BAUD, OVERSAMPLE, ACC_W));
  localparam logic [PW-1:0]    PH_LAST = PW'(OVERSAMPLE - 1);

  logic [ACC_W-1:0] inc_act_q, inc_act_d;
  logic [ACC_W-1:0] pend_inc_q, pend_inc_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic [PW-1:0]    os_phase_q, os_phase_d;
  logic             tick_q, tick_d;
  logic             tick_os_w, carry_nxt;
  logic             xfer, apply;

  baud_phase_acc #(.ACC_W(ACC_W)) u_acc (
    .clk       (CLK50MHZ),
    .rst_n     (RST_N),
    .en        (en),
    .sync      (sync),
    .inc       (inc_act_q),
    .carry     (tick_os_w),
    .carry_nxt (carry_nxt)
  );

  always_comb begin
    os_phase_d = os_phase_q;
    if (en && sync) begin
      os_phase_d = '0;
    end else if (tick_os_w) begin
      os_phase_d = os_phase_q + PW'(1);
    end

    // tick rides on the carry landing where os_phase will read OVERSAMPLE-1
    tick_d = carry_nxt && (os_phase_d == PH_LAST);

    // A transfer can only happen with nothing pending, so it never collides with an apply
    xfer        = cfg_valid && cfg_ready_q;
    apply       = !cfg_ready_q && (tick_q || !en || sync);
    inc_act_d   = inc_act_q;
    pend_inc_d  = pend_inc_q;
    cfg_ready_d = cfg_ready_q;
    if (xfer) begin
      pend_inc_d  = cfg_inc;
      cfg_ready_d = 1'b0;
    end else if (apply) begin
      inc_act_d   = pend_inc_q;
      cfg_ready_d = 1'b1;
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (!RST_N) begin
      inc_act_q   <= INC_DEF;
      pend_inc_q  <= INC_DEF;
      cfg_ready_q <= 1'b1;
      os_phase_q  <= '0;
      tick_q      <= 1'b0;
    end else begin
      inc_act_q   <= inc_act_d;
      pend_inc_q  <= pend_inc_d;
      cfg_ready_q <= cfg_ready_d;
      os_phase_q  <= os_phase_d;
      tick_q      <= tick_d;
    end
  end

`ifdef BAUD_GEN_MID_TICK_EN
  localparam logic [PW-1:0] PH_MID = PW'(OVERSAMPLE / 2 - 1);

  logic tick_mid_q, tick_mid_d;

  always_comb begin
    tick_mid_d = carry_nxt && (os_phase_d == PH_MID);
  end

  always_ff @(posedge CLK50MHZ) begin
    if (!RST_N) begin
      tick_mid_q <= 1'b0;
    end else begin
      tick_mid_q <= tick_mid_d;
    end
  end

  assign tick_mid = tick_mid_q;
`else
  assign tick_mid = 1'b0;
`endif

  assign cfg_ready = cfg_ready_q;
  assign tick_os   = tick_os_w;
  assign tick      = tick_q;
  assign os_phase  = os_phase_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen with default parameters (50 MHz, 115200, x16, 16-bit acc).
module tb_baud_tick_gen;

  localparam int ACC_W = 16;
`ifdef BAUD_GEN_MID_TICK_EN
  localparam bit MID_EN = 1'b1;
`else
  localparam bit MID_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             sync;
  logic             cfg_valid;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_ready;
  logic             tick_os;
  logic             tick;
  logic             tick_mid;
  logic [3:0]       os_phase;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .CLK50MHZ  (clk),
    .RST_N     (rst_n),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_inc   (cfg_inc),
    .cfg_ready (cfg_ready),
    .tick_os   (tick_os),
    .tick      (tick),
    .tick_mid  (tick_mid),
    .os_phase  (os_phase)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // number of accumulator carries after k enabled edges from acc=0
  function automatic longint carries(input longint k, input longint inc);
    return (k * inc) >> ACC_W;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_inc = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    step();
    checks++; if (tick_os !== 1'b0) begin failures++; $display("FAIL reset_tick_os: got %b expected 0", tick_os); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (tick_mid !== 1'b0) begin failures++; $display("FAIL reset_tick_mid: got %b expected 0", tick_mid); end
    checks++; if (os_phase !== 4'd0) begin failures++; $display("FAIL reset_os_phase: got %0d expected 0", os_phase); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    rst_n = 1'b1;
  endtask

  // Runs 50 bits at the default rate, then pauses en mid-bit and checks the resume.
  task automatic test_default_rate_and_hold();
    int first_os = 0, first_tick = 0, second_tick = 0, last_tick = 0, first_mid = 0;
    int n_os = 0, n_tick = 0, n_mid = 0, bad = 0, bad_hold = 0, bad_resume = 0, n_tick2 = 0;
    logic [3:0] held_ph;
    logic       exp_os, exp_tick;
    logic [3:0] exp_ph;
    en = 1'b1;
    for (int k = 1; k <= 21701; k++) begin
      step();
      if (tick_os) begin n_os++; if (first_os == 0) first_os = k; end
      if (tick) begin
        n_tick++;
        if (n_tick == 1) first_tick = k;
        if (n_tick == 2) second_tick = k;
        if (n_tick == 50) last_tick = k;
        if (!tick_os || os_phase != 4'd15) bad++;
      end
      if (tick_mid) begin
        n_mid++;
        if (first_mid == 0) first_mid = k;
        if (!tick_os || os_phase != 4'd7) bad++;
      end
    end
    checks++; if (first_os != 28) begin failures++; $display("FAIL first_tick_os: got %0d expected 28", first_os); end
    checks++; if (first_tick != 435) begin failures++; $display("FAIL first_tick: got %0d expected 435", first_tick); end
    checks++; if (second_tick != 869) begin failures++; $display("FAIL second_tick: got %0d expected 869", second_tick); end
    checks++; if (last_tick != 21701) begin failures++; $display("FAIL tick50: got %0d expected 21701", last_tick); end
    checks++; if (n_os != 800) begin failures++; $display("FAIL tick_os_count: got %0d expected 800", n_os); end
    checks++; if (n_tick != 50) begin failures++; $display("FAIL tick_count: got %0d expected 50", n_tick); end
    checks++; if (n_mid != (MID_EN ? 50 : 0)) begin failures++; $display("FAIL mid_count: got %0d expected %0d", n_mid, MID_EN ? 50 : 0); end
    checks++; if (first_mid != (MID_EN ? 218 : 0)) begin failures++; $display("FAIL first_mid: got %0d expected %0d", first_mid, MID_EN ? 218 : 0); end
    checks++; if (bad != 0) begin failures++; $display("FAIL tick_alignment: got %0d misaligned expected 0", bad); end

    repeat (99) step();
    en = 1'b0;
    held_ph = 4'(carries(21799, 2416) % 16);
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick_os || tick || tick_mid || os_phase != held_ph) bad_hold++;
    end
    checks++; if (bad_hold != 0) begin failures++; $display("FAIL en_low_hold: got %0d bad cycles expected 0", bad_hold); end
    checks++; if (os_phase !== 4'd3) begin failures++; $display("FAIL en_low_phase: got %0d expected 3", os_phase); end

    en = 1'b1;
    for (int k = 21801; k <= 22200; k++) begin
      step();
      exp_os   = (carries(k, 2416) != carries(k - 1, 2416));
      exp_ph   = 4'(carries(k - 1, 2416) % 16);
      exp_tick = exp_os && (exp_ph == 4'd15);
      if (tick) n_tick2++;
      if (tick_os !== exp_os || os_phase !== exp_ph || tick !== exp_tick) bad_resume++;
    end
    checks++; if (bad_resume != 0) begin failures++; $display("FAIL resume_trace: got %0d bad cycles expected 0", bad_resume); end
    checks++; if (n_tick2 != 1) begin failures++; $display("FAIL resume_tick_count: got %0d expected 1", n_tick2); end
  endtask

  task automatic test_cfg_rate_change();
    int t1 = 0, t2 = 0;
    logic rdy_at_tick = 1'b1;
    do_reset();
    en = 1'b1;
    repeat (100) step();
    cfg_valid = 1'b1; cfg_inc = 16'd201;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL cfg_ready_drop: got %b expected 0", cfg_ready); end
    for (int k = 102; k <= 436; k++) begin
      step();
      if (tick && t1 == 0) begin t1 = k; rdy_at_tick = cfg_ready; end
    end
    checks++; if (t1 != 435) begin failures++; $display("FAIL old_rate_tick: got %0d expected 435", t1); end
    checks++; if (rdy_at_tick !== 1'b0) begin failures++; $display("FAIL cfg_ready_at_tick: got %b expected 0", rdy_at_tick); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_ready_after_tick: got %b expected 1", cfg_ready); end
    for (int k = 437; k <= 5700; k++) begin
      step();
      if (tick && t2 == 0) t2 = k;
    end
    checks++; if (t2 != 5629) begin failures++; $display("FAIL new_rate_tick: got %0d expected 5629", t2); end
  endtask

  task automatic test_sync_on_tick();
    int f_os = 0, f_mid = 0, f_tick = 0;
    do_reset();
    en = 1'b1;
    repeat (199) step();
    cfg_valid = 1'b1; cfg_inc = 16'd1208;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL sync_cfg_pending: got %b expected 0", cfg_ready); end
    repeat (234) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++; if (tick !== 1'b0 || tick_os !== 1'b0) begin failures++; $display("FAIL sync_suppress: got tick=%b tick_os=%b expected 0 0", tick, tick_os); end
    checks++; if (os_phase !== 4'd0) begin failures++; $display("FAIL sync_phase: got %0d expected 0", os_phase); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL sync_apply_ready: got %b expected 1", cfg_ready); end
    for (int j = 1; j <= 900; j++) begin
      step();
      if (tick_os && f_os == 0) f_os = j;
      if (tick_mid && f_mid == 0) f_mid = j;
      if (tick && f_tick == 0) f_tick = j;
    end
    checks++; if (f_os != 55) begin failures++; $display("FAIL sync_first_os: got %0d expected 55", f_os); end
    checks++; if (f_mid != (MID_EN ? 435 : 0)) begin failures++; $display("FAIL sync_first_mid: got %0d expected %0d", f_mid, MID_EN ? 435 : 0); end
    checks++; if (f_tick != 869) begin failures++; $display("FAIL sync_first_tick: got %0d expected 869", f_tick); end
  endtask

  task automatic test_zero_inc();
    int n_os = 0, f_os = 0;
    cfg_valid = 1'b1; cfg_inc = 16'd0;
    step();
    cfg_valid = 1'b0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zero_apply_ready: got %b expected 1", cfg_ready); end
    for (int i = 0; i < 200; i++) begin step(); if (tick_os || tick) n_os++; end
    cfg_valid = 1'b1; cfg_inc = 16'd2416;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin step(); if (tick_os || tick) n_os++; end
    checks++; if (n_os != 0) begin failures++; $display("FAIL zero_frozen: got %0d ticks expected 0", n_os); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL zero_pending_held: got %b expected 0", cfg_ready); end
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL zero_resync_ready: got %b expected 1", cfg_ready); end
    for (int j = 1; j <= 100 && f_os == 0; j++) begin
      step();
      if (tick_os) f_os = j;
    end
    checks++; if (f_os != 28) begin failures++; $display("FAIL zero_resume_first_os: got %0d expected 28", f_os); end
  endtask

  task automatic test_reset_pending();
    int f_os = 0;
    cfg_valid = 1'b1; cfg_inc = 16'd201;
    step();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_pend_ready: got %b expected 0", cfg_ready); end
    repeat (10) step();
    do_reset();
    checks++; if (cfg_ready !== 1'b1 || os_phase !== 4'd0 || tick_os !== 1'b0) begin
      failures++; $display("FAIL rst_pend_state: got ready=%b phase=%0d tick_os=%b expected 1 0 0", cfg_ready, os_phase, tick_os);
    end
    en = 1'b1;
    for (int j = 1; j <= 400 && f_os == 0; j++) begin
      step();
      if (tick_os) f_os = j;
    end
    checks++; if (f_os != 28) begin failures++; $display("FAIL rst_pend_default_rate: got %0d expected 28", f_os); end
  endtask

  initial begin
    test_reset();
    test_default_rate_and_hold();
    test_cfg_rate_change();
    test_sync_on_tick();
    test_zero_inc();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
